// File: rtl/tdc_meas_sequencer_if.sv
// Host/TDC-core signal bundle for tdc_meas_sequencer.
// slave : sequencer side (takes commands and results, drives arm/enable/summary).
// master: host + TDC-core side (drives commands and results, consumes summary).
interface tdc_meas_sequencer_if #(
  parameter int TIME_W = 24
);
  // burst command
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        cmd_count;
  // TDC core
  logic              tdc_enable;
  logic              tdc_arm;
  logic              tdc_valid;
  logic [TIME_W-1:0] tdc_time_ps;
  logic              tdc_error;
  // burst summary
  logic              res_valid;
  logic              res_ready;
  logic [TIME_W+8:0] res_sum;
  logic [8:0]        res_good;
  logic [8:0]        res_timeouts;
  logic [TIME_W-1:0] res_min;
  logic [TIME_W-1:0] res_max;
  logic              busy;

  modport slave (
    input  cmd_valid, cmd_count, tdc_valid, tdc_time_ps, tdc_error, res_ready,
    output cmd_ready, tdc_enable, tdc_arm, res_valid, res_sum, res_good,
           res_timeouts, res_min, res_max, busy
  );

  modport master (
    output cmd_valid, cmd_count, tdc_valid, tdc_time_ps, tdc_error, res_ready,
    input  cmd_ready, tdc_enable, tdc_arm, res_valid, res_sum, res_good,
           res_timeouts, res_min, res_max, busy
  );
endinterface

// File: rtl/tdc_meas_sequencer.sv
// Purpose: runs N arm/settle/wait/gap measurements on the TDC core and returns one summary per burst.
// Latency: arm one cycle after command accept; summary GAP_CYCLES+1 cycles after the last result.
// Backpressure: cmd_ready only in IDLE; summary held in REPORT until res_ready.
//
// Ports: sys_clk_p / sys_rst_n (async active-low) plus seq_if (slave modport):
//   cmd_valid/cmd_ready/cmd_count  burst request (count 0 means 256)
//   tdc_enable/tdc_arm             core control, registered
//   tdc_valid/tdc_time_ps/tdc_error core result strobe and error level
//   res_valid/res_ready/res_*      burst summary handshake
//   busy                           high whenever not IDLE
// Option: define TDC_SEQ_MINMAX_EN to build min/max tracking; otherwise res_min/res_max are tied to 0.
module tdc_meas_sequencer #(
  parameter int TIME_W         = 24,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int ARM_SETTLE     = 3,
  parameter int GAP_CYCLES     = 10,
  parameter int RECOVER_CYCLES = 10
) (
  input  logic                 sys_clk_p,
  input  logic                 sys_rst_n,
  tdc_meas_sequencer_if.slave  seq_if
);

  localparam int DLY_MAX = (ARM_SETTLE > GAP_CYCLES)
                         ? ((ARM_SETTLE > RECOVER_CYCLES) ? ARM_SETTLE : RECOVER_CYCLES)
                         : ((GAP_CYCLES > RECOVER_CYCLES) ? GAP_CYCLES : RECOVER_CYCLES);
  localparam int DLY_W   = $clog2(DLY_MAX + 1);
  localparam int TMO_W   = $clog2(TIMEOUT_CYCLES);
  localparam int SUM_W   = TIME_W + 9;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_SETTLE, S_WAIT, S_GAP, S_RECOVER, S_REPORT
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [DLY_W-1:0]    r_dly;      // down-counter shared by SETTLE, GAP and RECOVER
  logic [TMO_W-1:0]    r_tmo;      // WAIT cycle index, 0 on the first WAIT cycle
  logic [8:0]          r_n;
  logic [SUM_W-1:0]    r_sum;
  logic [8:0]          r_good, r_touts;
  logic [8:0]          w_done_cnt;
  logic                w_lost;

  logic                r_cmd_ready, r_enable, r_arm, r_res_valid, r_busy;
  logic                w_cmd_ready_nxt, w_enable_nxt, w_arm_nxt, w_res_valid_nxt, w_busy_nxt;
  logic                w_load_res;
  logic [SUM_W-1:0]    r_res_sum;
  logic [8:0]          r_res_good, r_res_touts;

  assign w_done_cnt = r_good + r_touts;
  // valid has priority over error/timeout, so w_lost is only used when tdc_valid is low
  assign w_lost     = seq_if.tdc_error || (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

  // state register
  always_ff @(posedge sys_clk_p or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (seq_if.cmd_valid) w_state_nxt = S_ARM;
      S_ARM:     w_state_nxt = S_SETTLE;
      S_SETTLE:  if (r_dly == '0) w_state_nxt = S_WAIT;
      S_WAIT:    if (seq_if.tdc_valid) w_state_nxt = S_GAP;
                 else if (w_lost)      w_state_nxt = S_RECOVER;
      S_RECOVER: if (r_dly == '0) w_state_nxt = S_GAP;
      S_GAP:     if (r_dly == '0) w_state_nxt = (w_done_cnt == r_n) ? S_REPORT : S_ARM;
      S_REPORT:  if (seq_if.res_ready) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // output decode from the next state; registered below so every output is a flop
  always_comb begin
    w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_arm_nxt       = (w_state_nxt == S_ARM);
    w_enable_nxt    = (w_state_nxt != S_RECOVER);
    w_res_valid_nxt = (w_state_nxt == S_REPORT);
    w_load_res      = (w_state_nxt == S_REPORT) && (r_state != S_REPORT);
  end

`ifdef TDC_SEQ_MINMAX_EN
  logic [TIME_W-1:0] r_min, r_max, r_res_min, r_res_max;

  always_ff @(posedge sys_clk_p or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_min     <= '1;
      r_max     <= '0;
      r_res_min <= '1;
      r_res_max <= '0;
    end else begin
      if (r_state == S_IDLE && seq_if.cmd_valid) begin
        r_min <= '1;
        r_max <= '0;
      end else if (r_state == S_WAIT && seq_if.tdc_valid) begin
        if (seq_if.tdc_time_ps < r_min) r_min <= seq_if.tdc_time_ps;
        if (seq_if.tdc_time_ps > r_max) r_max <= seq_if.tdc_time_ps;
      end
      if (w_load_res) begin
        r_res_min <= r_min;
        r_res_max <= r_max;
      end
    end
  end

  assign seq_if.res_min = r_res_min;
  assign seq_if.res_max = r_res_max;
`else
  assign seq_if.res_min = '0;
  assign seq_if.res_max = '0;
`endif

  always_ff @(posedge sys_clk_p or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_arm       <= 1'b0;
      r_enable    <= 1'b0;
      r_res_valid <= 1'b0;
      r_dly       <= '0;
      r_tmo       <= '0;
      r_n         <= '0;
      r_sum       <= '0;
      r_good      <= '0;
      r_touts     <= '0;
      r_res_sum   <= '0;
      r_res_good  <= '0;
      r_res_touts <= '0;
    end else begin
      r_cmd_ready <= w_cmd_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_arm       <= w_arm_nxt;
      r_enable    <= w_enable_nxt;
      r_res_valid <= w_res_valid_nxt;

      if (w_state_nxt != r_state) begin
        case (w_state_nxt)
          S_SETTLE:  r_dly <= DLY_W'(ARM_SETTLE - 1);
          S_GAP:     r_dly <= DLY_W'(GAP_CYCLES - 1);
          S_RECOVER: r_dly <= DLY_W'(RECOVER_CYCLES - 1);
          default:   r_dly <= '0;
        endcase
      end else if (r_dly != '0) begin
        r_dly <= r_dly - 1'b1;
      end

      r_tmo <= (r_state == S_WAIT) ? r_tmo + 1'b1 : '0;

      if (r_state == S_IDLE && seq_if.cmd_valid) begin
        // count 0 encodes 256: the zero test becomes bit 8
        r_n     <= {(seq_if.cmd_count == 8'd0), seq_if.cmd_count};
        r_sum   <= '0;
        r_good  <= '0;
        r_touts <= '0;
      end else if (r_state == S_WAIT) begin
        if (seq_if.tdc_valid) begin
          r_sum  <= r_sum + SUM_W'(seq_if.tdc_time_ps);
          r_good <= r_good + 1'b1;
        end else if (w_lost) begin
          r_touts <= r_touts + 1'b1;
        end
      end

      if (w_load_res) begin
        r_res_sum   <= r_sum;
        r_res_good  <= r_good;
        r_res_touts <= r_touts;
      end
    end
  end

  assign seq_if.cmd_ready    = r_cmd_ready;
  assign seq_if.busy         = r_busy;
  assign seq_if.tdc_arm      = r_arm;
  assign seq_if.tdc_enable   = r_enable;
  assign seq_if.res_valid    = r_res_valid;
  assign seq_if.res_sum      = r_res_sum;
  assign seq_if.res_good     = r_res_good;
  assign seq_if.res_timeouts = r_res_touts;

endmodule
